// File: rtl/sad_pkg.sv
// Shared types and width helpers for the sum-of-absolute-differences engine.
package sad_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sad_state_e;

    // Result width: a block of n pixels of dw bits each sums to at most n*(2^dw-1).
    function automatic int sad_sw(input int dw, input int n);
        return dw + $clog2(n);
    endfunction

    // Beat address width, at least one bit even for a single-beat block.
    function automatic int sad_aw(input int k);
        if (k > 1) begin
            return $clog2(k);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/sad_lane_tree.sv
// Combinational LANES-way absolute difference followed by a balanced adder tree.
module sad_lane_tree
    import sad_pkg::*;
#(
    parameter int DW    = 8,
    parameter int LANES = 4
) (
    input  logic [LANES*DW-1:0]             a,
    input  logic [LANES*DW-1:0]             b,
    output logic [DW+$clog2(LANES)-1:0]     sum
);

    localparam int TW = DW + $clog2(LANES);

    // Heap-ordered tree: leaves at LANES..2*LANES-1, node k = node 2k + node 2k+1, root at 1.
    logic [TW-1:0] node_s [1:2*LANES-1];

    function automatic logic [DW-1:0] abs_diff(input logic [DW-1:0] x, input logic [DW-1:0] y);
        if (x >= y) begin
            return x - y;
        end else begin
            return y - x;
        end
    endfunction

    // Per-lane differences into the leaves, then reduce pairwise up to the root.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            node_s[LANES + j] = TW'(abs_diff(a[j*DW +: DW], b[j*DW +: DW]));
        end
        for (int k = LANES - 1; k >= 1; k--) begin
            node_s[k] = node_s[2*k] + node_s[2*k + 1];
        end
    end

    assign sum = node_s[1];

endmodule

// File: rtl/sad_engine.sv
// Parametrised SAD engine: reads LANES pixels of blocks A and B per beat from
// synchronous-read memories, accumulates |A-B| and holds the result in sad.
// Optional feature macro: SAD_EARLY_EXIT_EN adds thresh/early for early exit.
module sad_engine
    import sad_pkg::*;
#(
    parameter int DW    = 8,
    parameter int N     = 256,
    parameter int LANES = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             go,
    input  logic [LANES*DW-1:0]              A_data,
    input  logic [LANES*DW-1:0]              B_data,
    output logic                             AB_rd,
    output logic [sad_aw(N/LANES)-1:0]       AB_addr,
    output logic                             busy,
    output logic                             done,
`ifdef SAD_EARLY_EXIT_EN
    input  logic [sad_sw(DW, N)-1:0]         thresh,
    output logic                             early,
`endif
    output logic [sad_sw(DW, N)-1:0]         sad
);

    localparam int K  = N / LANES;
    localparam int AW = sad_aw(K);
    localparam int SW = sad_sw(DW, N);
    localparam int TW = DW + $clog2(LANES);

    if ((N % LANES) != 0) begin : g_bad_n
        $error("sad_engine: N must be a multiple of LANES");
    end
    if ((LANES < 1) || (LANES > 16) || ((LANES & (LANES - 1)) != 0)) begin : g_bad_lanes
        $error("sad_engine: LANES must be a power of 2 in 1..16");
    end

    sad_state_e    state_r, state_n;
    logic [AW-1:0] cnt_r, cnt_n;
    logic [SW-1:0] sum_r, sum_n;
    logic [SW-1:0] sad_r, sad_n;
    logic [SW-1:0] acc_s;
    logic [TW-1:0] beat_s;
    logic          valid_r;
    logic          rd_r;
    logic          busy_r;
    logic          done_r;
    logic          exit_s;
`ifdef SAD_EARLY_EXIT_EN
    logic [SW-1:0] thresh_r, thresh_n;
    logic          early_r, early_n;
`endif

    sad_lane_tree #(
        .DW    (DW),
        .LANES (LANES)
    ) u_tree (
        .a   (A_data),
        .b   (B_data),
        .sum (beat_s)
    );

    // Next-state, counter and accumulator logic; a beat is added the cycle after its read.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        sum_n   = sum_r;
        sad_n   = sad_r;
`ifdef SAD_EARLY_EXIT_EN
        thresh_n = thresh_r;
        early_n  = early_r;
`endif
        if (valid_r) begin
            acc_s = sum_r + SW'(beat_s);
        end else begin
            acc_s = sum_r;
        end
`ifdef SAD_EARLY_EXIT_EN
        exit_s = valid_r && (acc_s > thresh_r);
`else
        exit_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                cnt_n = '0;
                if (go) begin
                    state_n = READ;
                    sum_n   = '0;
`ifdef SAD_EARLY_EXIT_EN
                    thresh_n = thresh;
`endif
                end else begin
                    state_n = IDLE;
                end
            end
            READ: begin
                sum_n = acc_s;
                if (exit_s) begin
                    // Over threshold: the beat still in flight is simply never accumulated.
                    state_n = DONE;
                    cnt_n   = '0;
                    sad_n   = acc_s;
`ifdef SAD_EARLY_EXIT_EN
                    early_n = 1'b1;
`endif
                end else if (cnt_r == AW'(K - 1)) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_r + 1'b1;
                end
            end
            DRAIN: begin
                sum_n   = acc_s;
                sad_n   = acc_s;
                state_n = DONE;
`ifdef SAD_EARLY_EXIT_EN
                early_n = 1'b0;
`endif
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State, datapath and registered outputs; synchronous active-low reset aborts any run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            sum_r   <= '0;
            sad_r   <= '0;
            valid_r <= 1'b0;
            rd_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef SAD_EARLY_EXIT_EN
            thresh_r <= '0;
            early_r  <= 1'b0;
`endif
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            sum_r   <= sum_n;
            sad_r   <= sad_n;
            valid_r <= rd_r;
            rd_r    <= (state_n == READ);
            busy_r  <= (state_n != IDLE);
            done_r  <= (state_n == DONE);
`ifdef SAD_EARLY_EXIT_EN
            thresh_r <= thresh_n;
            early_r  <= early_n;
`endif
        end
    end

    assign AB_rd   = rd_r;
    assign AB_addr = cnt_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign sad     = sad_r;
`ifdef SAD_EARLY_EXIT_EN
    assign early   = early_r;
`endif

endmodule

// File: tb/tb_sad_engine.sv
// Self-checking bench for sad_engine: three configurations (256/4, 16/16, 8/1)
// with behavioural synchronous-read memories and an expected-result queue.
// Early-exit checks run only when SAD_EARLY_EXIT_EN is defined.
module tb_sad_engine;

    logic        clk;
    logic        rst;
    logic [2:0]  go_v;
    logic [2:0]  rd_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [31:0] sad_v  [3];
    logic [31:0] addr_v [3];

    logic [31:0]  a0, b0;
    logic [127:0] a1, b1;
    logic [7:0]   a2, b2;
    logic [5:0]   addr0;
    logic [0:0]   addr1;
    logic [2:0]   addr2;
    logic [15:0]  sad0;
    logic [11:0]  sad1;
    logic [10:0]  sad2;
`ifdef SAD_EARLY_EXIT_EN
    logic [15:0]  thresh0;
    logic         early0, early1, early2;
`endif

    logic [7:0] a_mem [3][256];
    logic [7:0] b_mem [3][256];
    longint     exp_q [$];
    int         errors = 0;
    int         checks = 0;
    int         kb_tab [3] = '{64, 1, 8};
    int         np_tab [3] = '{256, 16, 8};

    sad_engine #(.DW(8), .N(256), .LANES(4)) u_dut (
        .clk (clk), .rst (rst), .go (go_v[0]), .A_data (a0), .B_data (b0),
        .AB_rd (rd_v[0]), .AB_addr (addr0), .busy (busy_v[0]), .done (done_v[0]),
`ifdef SAD_EARLY_EXIT_EN
        .thresh (thresh0), .early (early0),
`endif
        .sad (sad0)
    );

    sad_engine #(.DW(8), .N(16), .LANES(16)) u_k1 (
        .clk (clk), .rst (rst), .go (go_v[1]), .A_data (a1), .B_data (b1),
        .AB_rd (rd_v[1]), .AB_addr (addr1), .busy (busy_v[1]), .done (done_v[1]),
`ifdef SAD_EARLY_EXIT_EN
        .thresh (12'hFFF), .early (early1),
`endif
        .sad (sad1)
    );

    sad_engine #(.DW(8), .N(8), .LANES(1)) u_l1 (
        .clk (clk), .rst (rst), .go (go_v[2]), .A_data (a2), .B_data (b2),
        .AB_rd (rd_v[2]), .AB_addr (addr2), .busy (busy_v[2]), .done (done_v[2]),
`ifdef SAD_EARLY_EXIT_EN
        .thresh (11'h7FF), .early (early2),
`endif
        .sad (sad2)
    );

    assign sad_v[0]  = 32'(sad0);
    assign sad_v[1]  = 32'(sad1);
    assign sad_v[2]  = 32'(sad2);
    assign addr_v[0] = 32'(addr0);
    assign addr_v[1] = 32'(addr1);
    assign addr_v[2] = 32'(addr2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: data for an address read in cycle t appears in cycle t+1.
    always @(posedge clk) begin
        if (rd_v[0]) begin
            for (int j = 0; j < 4; j++) begin
                a0[j*8 +: 8] <= a_mem[0][int'(addr0)*4 + j];
                b0[j*8 +: 8] <= b_mem[0][int'(addr0)*4 + j];
            end
        end
        if (rd_v[1]) begin
            for (int j = 0; j < 16; j++) begin
                a1[j*8 +: 8] <= a_mem[1][int'(addr1)*16 + j];
                b1[j*8 +: 8] <= b_mem[1][int'(addr1)*16 + j];
            end
        end
        if (rd_v[2]) begin
            a2 <= a_mem[2][int'(addr2)];
            b2 <= b_mem[2][int'(addr2)];
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_sad(input int idx, input int npix);
        longint s;
        int     d;
        s = 0;
        for (int k = 0; k < npix; k++) begin
            d = int'(a_mem[idx][k]) - int'(b_mem[idx][k]);
            s += (d < 0) ? -d : d;
        end
        return s;
    endfunction

    // mode 0: A=k&FF,B=0  1: A=FF,B=0  2: A=0,B=FF  3: A==B random  4: random
    task automatic fill(input int idx, input int mode);
        logic [7:0] r;
        for (int k = 0; k < 256; k++) begin
            r = 8'($urandom_range(0, 255));
            case (mode)
                0: begin a_mem[idx][k] = 8'(k);  b_mem[idx][k] = 8'h00; end
                1: begin a_mem[idx][k] = 8'hFF;  b_mem[idx][k] = 8'h00; end
                2: begin a_mem[idx][k] = 8'h00;  b_mem[idx][k] = 8'hFF; end
                3: begin a_mem[idx][k] = r;      b_mem[idx][k] = r;     end
                default: begin a_mem[idx][k] = r; b_mem[idx][k] = 8'($urandom_range(0, 255)); end
            endcase
        end
    endtask

    task automatic run(input int idx, input bit hold);
        int     n, nrd, bad, kb, dcount;
        bit     seen;
        longint exp;
        kb = kb_tab[idx];
        exp_q.push_back(ref_sad(idx, np_tab[idx]));
        @(negedge clk);
        go_v[idx] = 1'b1;
        n = 0; nrd = 0; bad = 0; seen = 1'b0;
        while (!seen && n < kb + 20) begin
            @(negedge clk);
            n++;
            if (rd_v[idx]) begin
                if (addr_v[idx] != 32'(nrd)) bad++;
                nrd++;
            end
            if (done_v[idx]) seen = 1'b1;
            if (n == 1 && !hold) go_v[idx] = 1'b0;
        end
        check("done_seen", longint'(seen), 1);
        check("latency", n, kb + 2);
        check("reads", nrd, kb);
        check("addr_seq", bad, 0);
        exp = exp_q.pop_front();
        check("sad", sad_v[idx], exp);
`ifdef SAD_EARLY_EXIT_EN
        if (idx == 0) check("early_normal", longint'(early0), 0);
`endif
        @(negedge clk);
        check("done_pulse", longint'(done_v[idx]), 0);
        check("busy_after", longint'(busy_v[idx]), 0);
        check("addr_idle", addr_v[idx], 0);
        check("sad_held", sad_v[idx], exp);
        if (hold) begin
            go_v[idx] = 1'b0;
            dcount = 0;
            repeat (kb + 20) begin
                @(negedge clk);
                if (done_v[idx]) dcount++;
            end
            check("extra_run", dcount, 0);
        end
    endtask

`ifdef SAD_EARLY_EXIT_EN
    task automatic run_early();
        int n, nrd, last;
        bit seen;
        for (int k = 0; k < 256; k++) begin
            a_mem[0][k] = (k % 2 == 1) ? 8'd20 : 8'd0;
            b_mem[0][k] = 8'd10;
        end
        thresh0 = 16'd100;
        exp_q.push_back(120);
        @(negedge clk);
        go_v[0] = 1'b1;
        n = 0; nrd = 0; last = -1; seen = 1'b0;
        while (!seen && n < 90) begin
            @(negedge clk);
            n++;
            if (rd_v[0]) begin
                last = int'(addr0);
                nrd++;
            end
            if (done_v[0]) seen = 1'b1;
            if (n == 1) go_v[0] = 1'b0;
        end
        check("ee_latency", n, 5);
        check("ee_last_addr", last, 3);
        check("ee_reads", nrd, 4);
        check("ee_sad", sad_v[0], exp_q.pop_front());
        check("ee_early", longint'(early0), 1);
        @(negedge clk);
        check("ee_early_held", longint'(early0), 1);
        check("ee_busy_after", longint'(busy_v[0]), 0);
        thresh0 = 16'hFFFF;
    endtask
`endif

    initial begin
        int c, dcount;
        rst  = 1'b0;
        go_v = 3'b000;
`ifdef SAD_EARLY_EXIT_EN
        thresh0 = 16'hFFFF;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", longint'(busy_v[0]), 0);
        check("rst_rd", longint'(rd_v[0]), 0);
        check("rst_addr", addr_v[0], 0);
        check("rst_done", longint'(done_v[0]), 0);
        check("rst_sad", sad_v[0], 0);
        rst = 1'b1;

        fill(0, 0); run(0, 1'b0);
        check("ramp_const", sad_v[0], 32640);
        fill(0, 1); run(0, 1'b0);
        check("max_const", sad_v[0], 65280);
        fill(0, 2); run(0, 1'b0);

        // Abort mid-run at beat 10.
        fill(0, 4);
        @(negedge clk); go_v[0] = 1'b1;
        @(negedge clk); go_v[0] = 1'b0;
        c = 0;
        while (!(rd_v[0] && addr0 == 6'd10) && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("abort_reach", addr_v[0], 10);
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", longint'(busy_v[0]), 0);
        check("abort_rd", longint'(rd_v[0]), 0);
        check("abort_sad", sad_v[0], 0);
        check("abort_done", longint'(done_v[0]), 0);
        rst = 1'b1;
        dcount = 0;
        repeat (80) begin
            @(negedge clk);
            if (done_v[0]) dcount++;
        end
        check("abort_no_done", dcount, 0);

        fill(0, 3); run(0, 1'b1);
        fill(0, 4); run(0, 1'b0);

        fill(1, 4); run(1, 1'b0);
        fill(1, 1); run(1, 1'b0);
        fill(2, 4); run(2, 1'b0);
        fill(2, 2); run(2, 1'b0);

`ifdef SAD_EARLY_EXIT_EN
        run_early();
        fill(0, 4); run(0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
